pump_lead_lag_scheduler: RTL
============================

// Module: pump_lead_lag_scheduler
// PURPOSE
//  Schedules two pump_controller_robust channels (A, B) sharing one tank.
//  Turns one demand request into a run enable for exactly one pump.
//  Enforces minimum on and off times so the pumps do not short-cycle.
//  Alternates the lead pump after every completed run, and fails over to the
//  healthy pump when a channel's fault_latched rises.
// PARAMETERS
//  CLK_HZ         100_000_000  clock frequency; sets the 1 ms tick
//  MIN_ON_MS      1000         minimum run time before a demand-stop is honoured
//  MIN_OFF_MS     2000         minimum idle time after any stop before a new start
//  SWITCH_GAP_MS  100          both-off gap during failover
//  CNT_W          16           width of the start counters
// PORTS
//  clk              in   1      system clock, single domain
//  rst_n            in   1      synchronous, active-low reset
//  req_run          in   1      debounced demand (1 = water needed)
//  fault_a          in   1      fault_latched from channel A
//  fault_b          in   1      fault_latched from channel B
//  pump_en_a        out  1      run enable to channel A
//  pump_en_b        out  1      run enable to channel B
//  lead_b           out  1      0 = A is lead, 1 = B is lead
//  alarm_all_fault  out  1      both channels faulted
//  starts_a         out  CNT_W  saturating count of A starts
//  starts_b         out  CNT_W  saturating count of B starts
// BEHAVIOUR
//  - Reset values: all outputs 0, state IDLE, timers 0, off-timer expired
//    (a start is allowed immediately after reset).
//  - ms tick: 1-cycle pulse every CLK_HZ/1000 clocks, free-running from reset.
//    Timers count ticks and saturate at their limit.
//  - All outputs are registered. A transition taken on cycle N shows on the
//    outputs at cycle N+1.
//  - Never both pump_en_a and pump_en_b high, in any state.
//  - Pick rule: target = lead if lead is healthy, else the other pump if it is
//    healthy, else none.
//  - IDLE: both enables 0.
//      * If req_run, off-timer >= MIN_OFF_MS and a target exists: go to RUN on
//        target, clear on-timer, increment that pump's start counter.
//      * If both faults: go to ALL_FAULT.
//  - RUN: enable for the selected pump only.
//      * If the selected pump's fault rises and the other pump is healthy: go
//        to SWITCH and clear the gap timer.
//      * If the selected pump's fault rises and the other is faulted: go to
//        ALL_FAULT.
//      * If !req_run and on-timer >= MIN_ON_MS: go to IDLE, toggle lead_b,
//        clear off-timer.
//      * !req_run before MIN_ON_MS: stay in RUN until MIN_ON_MS.
//      * Fault takes priority over the demand-stop when both occur in the same
//        cycle.
//  - SWITCH: both enables 0.
//      * After SWITCH_GAP_MS: if req_run and the other pump is still healthy, go
//        to RUN on it (start counter +1, lead unchanged, MIN_OFF not applied).
//      * Otherwise go to IDLE and clear off-timer.
//      * Other pump faults during the gap: go to ALL_FAULT.
//  - ALL_FAULT: both enables 0, alarm_all_fault = 1.
//      * When either fault clears: go to IDLE and clear off-timer.
//  - A fault on the idle (non-selected) pump has no effect on the running pump.
//    It only changes the pick rule.
//  - Start counters hold at all-ones and do not wrap.
//  - Reset asserted mid-run: outputs drop to 0 on the next clock edge. Reset
//    overrides every transition.
// STRUCTURE
//  - pump_sched_pkg:
//      * typedef enum logic [1:0] {IDLE, RUN, SWITCH, ALL_FAULT} sched_state_t
//      * typedef enum logic {PUMP_A, PUMP_B} pump_id_t
//      * ms_div(CLK_HZ) function
//  - Sub-module ms_tick_gen #(CLK_HZ): divider with sync active-low reset.
//    It is reused by the debounce logic.
//  - Top level: one FSM, three ms timers (on, off, gap), two start counters.
// TESTING (bench: CLK_HZ=10_000 so 1 tick = 10 clk, MIN_ON_MS=5, MIN_OFF_MS=8, SWITCH_GAP_MS=2)
//  1. Reset, req_run=1 -> pump_en_a=1 one clock later, starts_a=1, lead_b=0.
//  2. Drop req_run 20 clk after start -> A stays on until on-timer hits 5 ms,
//     then off; lead_b=1. Raise req_run immediately -> no start until 8 ms,
//     then pump_en_b=1.
//  3. fault_a=1 while A runs -> pump_en_a=0 next clock; both off for 2 ms;
//     pump_en_b=1, starts_b increments, lead_b unchanged.
//  4. fault_a and fault_b both 1 -> alarm_all_fault=1 and both enables 0.
//     Clear fault_b -> IDLE, then B starts after 8 ms.
//  5. req_run drop and fault on the running pump in the same cycle -> failover
//     path is taken, SWITCH then IDLE; no lead toggle.
//  6. rst_n=0 for one clock mid-RUN -> all outputs 0 and counters 0; assert
//     pump_en_a & pump_en_b is never true throughout the test.

Source files
------------

// File: rtl/pump_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pump_sched_pkg
//  Brief   : Shared types and helper functions for the lead/lag pump
//            scheduler and its millisecond tick divider.
//  Revision: 1.0  initial release
// ============================================================================
package pump_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        SWITCH    = 2'd2,
        ALL_FAULT = 2'd3
    } sched_state_t;

    typedef enum logic {
        PUMP_A = 1'b0,
        PUMP_B = 1'b1
    } pump_id_t;

    // Clocks per millisecond, never less than one so the divider stays legal
    function automatic int ms_div(input int clk_hz);
        int d;
        d = clk_hz / 1000;
        return (d < 1) ? 1 : d;
    endfunction

    // Bits needed to hold 0..max_val, at least one bit
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pump_lead_lag_scheduler_ms_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module  : ms_tick_gen
//  Brief   : Free-running divider producing a one-cycle pulse every
//            millisecond of the given clock frequency.
//  Revision: 1.0  initial release
// ============================================================================
module ms_tick_gen
    import pump_sched_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
)(
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int DIV  = ms_div(CLK_HZ);
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = (r_cnt == c_last);
    assign o_tick = r_tick;

    // Count clocks and pulse once per wrap of the divider
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
            r_tick <= w_wrap;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pump_lead_lag_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : pump_lead_lag_scheduler
//  Brief   : Turns one demand request into a run enable for exactly one of
//            two pumps, with min on/off times, lead alternation and failover.
//  Revision: 1.0  initial release
// ============================================================================
module pump_lead_lag_scheduler
    import pump_sched_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int MIN_ON_MS     = 1000,
    parameter int MIN_OFF_MS    = 2000,
    parameter int SWITCH_GAP_MS = 100,
    parameter int CNT_W         = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_run,
    input  logic             i_fault_a,
    input  logic             i_fault_b,
    output logic             o_pump_en_a,
    output logic             o_pump_en_b,
    output logic             o_lead_b,
    output logic             o_alarm_all_fault,
    output logic [CNT_W-1:0] o_starts_a,
    output logic [CNT_W-1:0] o_starts_b
);

    localparam int ON_W  = cnt_w(MIN_ON_MS);
    localparam int OFF_W = cnt_w(MIN_OFF_MS);
    localparam int GAP_W = cnt_w(SWITCH_GAP_MS);
    localparam logic [ON_W-1:0]  c_on_lim  = ON_W'(MIN_ON_MS);
    localparam logic [OFF_W-1:0] c_off_lim = OFF_W'(MIN_OFF_MS);
    localparam logic [GAP_W-1:0] c_gap_lim = GAP_W'(SWITCH_GAP_MS);

    sched_state_t     r_state, w_state_nxt;
    pump_id_t         r_sel, w_sel_nxt;
    logic             r_lead, w_lead_nxt;
    logic [ON_W-1:0]  r_on_ms;
    logic [OFF_W-1:0] r_off_ms;
    logic [GAP_W-1:0] r_gap_ms;
    logic [CNT_W-1:0] r_starts_a, r_starts_b;
    logic             r_en_a, r_en_b, r_alarm;

    logic     w_tick;
    logic     w_on_done, w_off_done, w_gap_done;
    logic     w_clr_on, w_clr_off, w_clr_gap, w_inc_a, w_inc_b;
    logic     w_fault_lead, w_fault_sel, w_fault_oth;
    pump_id_t w_lead_id, w_other_lead, w_target, w_other_sel;
    logic     w_en_a_nxt, w_en_b_nxt, w_alarm_nxt;

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    assign w_on_done  = (r_on_ms  >= c_on_lim);
    assign w_off_done = (r_off_ms >= c_off_lim);
    assign w_gap_done = (r_gap_ms >= c_gap_lim);

    // Pick rule: lead if healthy, otherwise the other pump
    assign w_lead_id    = r_lead ? PUMP_B : PUMP_A;
    assign w_other_lead = r_lead ? PUMP_A : PUMP_B;
    assign w_fault_lead = r_lead ? i_fault_b : i_fault_a;
    assign w_target     = w_fault_lead ? w_other_lead : w_lead_id;

    // Health of the running pump and of its partner
    assign w_other_sel  = (r_sel == PUMP_A) ? PUMP_B : PUMP_A;
    assign w_fault_sel  = (r_sel == PUMP_A) ? i_fault_a : i_fault_b;
    assign w_fault_oth  = (r_sel == PUMP_A) ? i_fault_b : i_fault_a;

    // Millisecond timers: clear on request, otherwise count ticks up to limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_on_ms  <= '0;
            r_off_ms <= c_off_lim;
            r_gap_ms <= '0;
        end else begin
            if (w_clr_on)
                r_on_ms <= '0;
            else if (w_tick && !w_on_done)
                r_on_ms <= r_on_ms + ON_W'(1);

            if (w_clr_off)
                r_off_ms <= '0;
            else if (w_tick && !w_off_done)
                r_off_ms <= r_off_ms + OFF_W'(1);

            if (w_clr_gap)
                r_gap_ms <= '0;
            else if (w_tick && !w_gap_done)
                r_gap_ms <= r_gap_ms + GAP_W'(1);
        end
    end

    // State register with selected pump, lead flag and saturating start counts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sel      <= PUMP_A;
            r_lead     <= 1'b0;
            r_starts_a <= '0;
            r_starts_b <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_lead  <= w_lead_nxt;
            if (w_inc_a && (r_starts_a != '1))
                r_starts_a <= r_starts_a + CNT_W'(1);
            if (w_inc_b && (r_starts_b != '1))
                r_starts_b <= r_starts_b + CNT_W'(1);
        end
    end

    // Next-state logic; a fault on the running pump outranks a demand-stop
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_lead_nxt  = r_lead;
        w_clr_on    = 1'b0;
        w_clr_off   = 1'b0;
        w_clr_gap   = 1'b0;
        w_inc_a     = 1'b0;
        w_inc_b     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_fault_a && i_fault_b) begin
                    w_state_nxt = ALL_FAULT;
                end else if (i_req_run && w_off_done) begin
                    w_state_nxt = RUN;
                    w_sel_nxt   = w_target;
                    w_clr_on    = 1'b1;
                    w_inc_a     = (w_target == PUMP_A);
                    w_inc_b     = (w_target == PUMP_B);
                end
            end
            RUN: begin
                if (w_fault_sel) begin
                    if (!w_fault_oth) begin
                        w_state_nxt = SWITCH;
                        w_clr_gap   = 1'b1;
                    end else begin
                        w_state_nxt = ALL_FAULT;
                    end
                end else if (!i_req_run && w_on_done) begin
                    w_state_nxt = IDLE;
                    w_lead_nxt  = ~r_lead;
                    w_clr_off   = 1'b1;
                end
            end
            SWITCH: begin
                if (w_fault_oth) begin
                    w_state_nxt = ALL_FAULT;
                end else if (w_gap_done) begin
                    if (i_req_run) begin
                        // Failover restart skips the minimum off time
                        w_state_nxt = RUN;
                        w_sel_nxt   = w_other_sel;
                        w_clr_on    = 1'b1;
                        w_inc_a     = (w_other_sel == PUMP_A);
                        w_inc_b     = (w_other_sel == PUMP_B);
                    end else begin
                        w_state_nxt = IDLE;
                        w_clr_off   = 1'b1;
                    end
                end
            end
            ALL_FAULT: begin
                if (!i_fault_a || !i_fault_b) begin
                    w_state_nxt = IDLE;
                    w_clr_off   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the next state so outputs are registered copies
    always_comb begin
        w_en_a_nxt  = (w_state_nxt == RUN) && (w_sel_nxt == PUMP_A);
        w_en_b_nxt  = (w_state_nxt == RUN) && (w_sel_nxt == PUMP_B);
        w_alarm_nxt = (w_state_nxt == ALL_FAULT);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en_a  <= 1'b0;
            r_en_b  <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_en_a  <= w_en_a_nxt;
            r_en_b  <= w_en_b_nxt;
            r_alarm <= w_alarm_nxt;
        end
    end

    assign o_pump_en_a       = r_en_a;
    assign o_pump_en_b       = r_en_b;
    assign o_lead_b          = r_lead;
    assign o_alarm_all_fault = r_alarm;
    assign o_starts_a        = r_starts_a;
    assign o_starts_b        = r_starts_b;

endmodule
`default_nettype wire
